// File: rtl/arp_resolver_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// arp_resolver_pkg : shared state encodings and address constants
// Rev 1.0
// ------------------------------------------------------------------
package arp_resolver_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOOKUP  = 3'd1;
  localparam logic [2:0] ST_QUERY   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_RESPOND = 3'd4;

  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] IP_BROADCAST  = 32'hFFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/arp_resolver_cache.sv
`default_nettype none
// ------------------------------------------------------------------
// arp_resolver_cache : direct-mapped IP->MAC store, async read, clear wins over write
// Rev 1.0
// ------------------------------------------------------------------
module arp_resolver_cache #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [31:0]           wr_tag,
  input  logic [47:0]           wr_mac,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [31:0]           rd_tag,
  output logic [47:0]           rd_mac
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [31:0]      tag_q [DEPTH];
  logic [31:0]      tag_d [DEPTH];
  logic [47:0]      mac_q [DEPTH];
  logic [47:0]      mac_d [DEPTH];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    mac_d   = mac_q;
    if (clear) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      mac_d[wr_idx]   = wr_mac;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    mac_q <= mac_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_mac   = mac_q[rd_idx];

endmodule
`default_nettype wire

// File: rtl/arp_resolver.sv
`default_nettype none
// ------------------------------------------------------------------
// arp_resolver : resolves next-hop MAC for IPv4 TX with cache, who-has retries
// Rev 1.0
// ------------------------------------------------------------------
module arp_resolver
  import arp_resolver_pkg::*;
#(
  parameter int CACHE_ADDR_WIDTH = 4,
  parameter int RETRY_COUNT      = 3,
  parameter int RETRY_INTERVAL   = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,
  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,
  output logic        m_query_valid,
  input  logic        m_query_ready,
  output logic [31:0] m_query_ip,
  input  logic        s_update_valid,
  input  logic [31:0] s_update_ip,
  input  logic [47:0] s_update_mac,
  input  logic        cache_clear,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask
);

  localparam int TIMER_W = $clog2(RETRY_INTERVAL);
  localparam int ATT_W   = $clog2(RETRY_COUNT + 1);

  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(RETRY_INTERVAL - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);
  localparam logic [ATT_W-1:0]   ATT_INIT     = ATT_W'(RETRY_COUNT);
  localparam logic [ATT_W-1:0]   ATT_ONE      = ATT_W'(1);

  logic [2:0]         state_q, state_d;
  logic [31:0]        target_q, target_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ATT_W-1:0]   attempts_q, attempts_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_error_q, resp_error_d;
  logic [47:0]        resp_mac_q, resp_mac_d;
  logic               query_valid_q, query_valid_d;
  logic [31:0]        query_ip_q, query_ip_d;

  logic        cache_valid;
  logic [31:0] cache_tag;
  logic [47:0] cache_mac;

  logic accept;
  logic is_bcast;
  logic off_subnet;
  logic upd_match;

  arp_resolver_cache #(
    .ADDR_WIDTH (CACHE_ADDR_WIDTH)
  ) u_cache (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cache_clear),
    .wr_en    (s_update_valid),
    .wr_idx   (s_update_ip[CACHE_ADDR_WIDTH-1:0]),
    .wr_tag   (s_update_ip),
    .wr_mac   (s_update_mac),
    .rd_idx   (target_q[CACHE_ADDR_WIDTH-1:0]),
    .rd_valid (cache_valid),
    .rd_tag   (cache_tag),
    .rd_mac   (cache_mac)
  );

  assign accept     = arp_request_valid && req_ready_q;
  assign is_bcast   = (arp_request_ip == IP_BROADCAST) ||
                      ((arp_request_ip | subnet_mask) == IP_BROADCAST);
  assign off_subnet = (arp_request_ip & subnet_mask) != (local_ip & subnet_mask);
  assign upd_match  = s_update_valid && (s_update_ip == target_q);

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    timer_d       = timer_q;
    attempts_d    = attempts_q;
    resp_valid_d  = resp_valid_q;
    resp_error_d  = resp_error_q;
    resp_mac_d    = resp_mac_q;
    query_valid_d = query_valid_q;
    query_ip_d    = query_ip_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_bcast) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            resp_mac_d   = BROADCAST_MAC;
            state_d      = ST_RESPOND;
          end else begin
            target_d = off_subnet ? gateway_ip : arp_request_ip;
            state_d  = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        // A binding arriving this very cycle is fresher than the array contents.
        if (upd_match) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_mac_d   = s_update_mac;
          state_d      = ST_RESPOND;
        end else if (cache_valid && (cache_tag == target_q)) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_mac_d   = cache_mac;
          state_d      = ST_RESPOND;
        end else begin
          attempts_d    = ATT_INIT;
          query_valid_d = 1'b1;
          query_ip_d    = target_q;
          state_d       = ST_QUERY;
        end
      end
      ST_QUERY: begin
        if (query_valid_q && m_query_ready) begin
          query_valid_d = 1'b0;
          timer_d       = TIMER_RELOAD;
          attempts_d    = attempts_q - ATT_ONE;
          state_d       = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (upd_match) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b0;
          resp_mac_d   = s_update_mac;
          state_d      = ST_RESPOND;
        end else if (timer_q == '0) begin
          if (attempts_q != '0) begin
            query_valid_d = 1'b1;
            query_ip_d    = target_q;
            state_d       = ST_QUERY;
          end else begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_mac_d   = '0;
            state_d      = ST_RESPOND;
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      ST_RESPOND: begin
        if (arp_response_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        resp_valid_d  = 1'b0;
        query_valid_d = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      timer_q       <= '0;
      attempts_q    <= '0;
      req_ready_q   <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_mac_q    <= '0;
      query_valid_q <= 1'b0;
      query_ip_q    <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      timer_q       <= timer_d;
      attempts_q    <= attempts_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_mac_q    <= resp_mac_d;
      query_valid_q <= query_valid_d;
      query_ip_q    <= query_ip_d;
    end
  end

  assign arp_request_ready  = req_ready_q;
  assign arp_response_valid = resp_valid_q;
  assign arp_response_error = resp_error_q;
  assign arp_response_mac   = resp_mac_q;
  assign m_query_valid      = query_valid_q;
  assign m_query_ip         = query_ip_q;

endmodule
`default_nettype wire
